// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_pkg
//  Description : Shared types and constants for the EX->MEM pipeline slice:
//                control-bit struct and the packed payload width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    // Memory/write-back control bits carried alongside the EX result
    typedef struct packed {
        logic MR;    // memory read
        logic MW;    // memory write
        logic MReg;  // write-back mux selects memory data
        logic EnRW;  // register-file write enable
    } exmem_ctrl_t;

    localparam int unsigned c_EXMEM_CTRL_W = $bits(exmem_ctrl_t);

    // Width of the packed payload {ALU, RD2, WN, ctrl} for given field widths
    function automatic int unsigned exmem_payload_w(input int unsigned data_w,
                                                    input int unsigned reg_aw);
        return 2 * data_w + reg_aw + c_EXMEM_CTRL_W;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_skid_buf.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_skid_buf
//  Description : Generic 2-entry skid buffer (main entry M drives the output,
//                skid entry S absorbs one beat under backpressure). in_ready
//                is registered so no combinational path runs from out_ready.
//                flush invalidates both entries; payload registers keep data.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_skid_buf #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         r_m_valid;
    logic         r_s_valid;
    logic [W-1:0] r_m_data;
    logic [W-1:0] r_s_data;
    logic         r_in_ready;

    logic w_accept;
    logic w_release;
    logic w_s_valid_nxt;

    assign w_accept  = in_valid & r_in_ready;
    assign w_release = r_m_valid & out_ready;

    // S stays occupied unless drained into M; it fills only when M is held
    assign w_s_valid_nxt = r_s_valid ? ~w_release
                                     : (w_accept & r_m_valid & ~w_release);

    // Entry movement: S->M on release, otherwise fill M first, then S
    always_ff @(posedge clk) begin
        if (reset) begin
            r_m_valid  <= 1'b0;
            r_s_valid  <= 1'b0;
            r_m_data   <= '0;
            r_s_data   <= '0;
            r_in_ready <= 1'b1;
        end else if (flush) begin
            r_m_valid  <= 1'b0;
            r_s_valid  <= 1'b0;
            r_in_ready <= 1'b1;
        end else begin
            if (w_release && r_s_valid) begin
                r_m_data  <= r_s_data;
                r_m_valid <= 1'b1;
                r_s_valid <= 1'b0;
            end else if (w_accept && (!r_m_valid || w_release)) begin
                r_m_data  <= in_data;
                r_m_valid <= 1'b1;
            end else if (w_accept) begin
                r_s_data  <= in_data;
                r_s_valid <= 1'b1;
            end else if (w_release) begin
                r_m_valid <= 1'b0;
            end
            r_in_ready <= ~w_s_valid_nxt;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_m_valid;
    assign out_data  = r_m_data;

endmodule
`default_nettype wire

// File: rtl/ex_mem_pipe_stage.sv
`default_nettype none
// ============================================================================
//  Module      : ex_mem_pipe_stage
//  Description : EX->MEM pipeline register with valid/ready handshake,
//                2-entry skid buffer, flush, and control gating so that a
//                bubble never writes memory or the register file.
//                Optional performance counters when EX_MEM_PIPE_PERF_EN is
//                defined (stall_cnt, bubble_cnt, flush_cnt).
//  Revision    : 1.0 - initial release
// ============================================================================
module ex_mem_pipe_stage
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] ALU_in,
    input  logic [DATA_W-1:0] RD2_in,
    input  logic [REG_AW-1:0] WN_in,
    input  logic              MR_in,
    input  logic              MW_in,
    input  logic              MReg_in,
    input  logic              EnRW_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] ALU_out,
    output logic [DATA_W-1:0] RD2_out,
    output logic [REG_AW-1:0] WN_out,
    output logic              MR_out,
    output logic              MW_out,
    output logic              MReg_out,
`ifdef EX_MEM_PIPE_PERF_EN
    output logic              EnRW_out,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`else
    output logic              EnRW_out
`endif
);

    localparam int unsigned c_PAYLOAD_W = exmem_payload_w(DATA_W, REG_AW);

    exmem_ctrl_t             w_ctrl_in;
    exmem_ctrl_t             w_ctrl_out;
    logic [c_PAYLOAD_W-1:0]  w_pl_in;
    logic [c_PAYLOAD_W-1:0]  w_pl_out;
    logic                    w_in_ready;
    logic                    w_out_valid;

    assign w_ctrl_in = '{MR: MR_in, MW: MW_in, MReg: MReg_in, EnRW: EnRW_in};
    assign w_pl_in   = {ALU_in, RD2_in, WN_in, w_ctrl_in};

    pipe_skid_buf #(
        .W (c_PAYLOAD_W)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (w_in_ready),
        .in_data   (w_pl_in),
        .out_valid (w_out_valid),
        .out_ready (out_ready),
        .out_data  (w_pl_out)
    );

    assign {ALU_out, RD2_out, WN_out, w_ctrl_out} = w_pl_out;

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;

    // Control bits only take effect for a valid beat
    assign MR_out   = w_ctrl_out.MR   & w_out_valid;
    assign MW_out   = w_ctrl_out.MW   & w_out_valid;
    assign MReg_out = w_ctrl_out.MReg & w_out_valid;
    assign EnRW_out = w_ctrl_out.EnRW & w_out_valid;

`ifdef EX_MEM_PIPE_PERF_EN
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_bubble_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic             w_flush_hit;

    // A flush counts only if it killed a held beat (not one released this
    // edge), a skid beat (in_ready low), or a beat accepted this edge
    assign w_flush_hit = flush & ((w_out_valid & ~out_ready) | ~w_in_ready |
                                  (in_valid & w_in_ready));

    // Saturating event counters
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
            r_flush_cnt  <= '0;
        end else begin
            if (w_out_valid && !out_ready && !(&r_stall_cnt))
                r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
            if (!w_out_valid && !(&r_bubble_cnt))
                r_bubble_cnt <= r_bubble_cnt + c_CNT_ONE;
            if (w_flush_hit && !(&r_flush_cnt))
                r_flush_cnt <= r_flush_cnt + c_CNT_ONE;
        end
    end

    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;
    assign flush_cnt  = r_flush_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_pipe_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ex_mem_pipe_stage
//  Description : Self-checking bench for ex_mem_pipe_stage. The reference is
//                a 2-deep FIFO of expected beats; a monitor process pops it
//                whenever the DUT hands a beat to MEM.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_mem_pipe_stage;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_AW = 4;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned PW     = 2 * DATA_W + REG_AW + 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] ALU_in = '0;
    logic [DATA_W-1:0] RD2_in = '0;
    logic [REG_AW-1:0] WN_in = '0;
    logic              MR_in = 1'b0, MW_in = 1'b0, MReg_in = 1'b0, EnRW_in = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] ALU_out, RD2_out;
    logic [REG_AW-1:0] WN_out;
    logic              MR_out, MW_out, MReg_out, EnRW_out;
`ifdef EX_MEM_PIPE_PERF_EN
    logic [CNT_W-1:0]  stall_cnt, bubble_cnt, flush_cnt;
`endif

    ex_mem_pipe_stage #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ALU_in    (ALU_in),
        .RD2_in    (RD2_in),
        .WN_in     (WN_in),
        .MR_in     (MR_in),
        .MW_in     (MW_in),
        .MReg_in   (MReg_in),
        .EnRW_in   (EnRW_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ALU_out   (ALU_out),
        .RD2_out   (RD2_out),
        .WN_out    (WN_out),
        .MR_out    (MR_out),
        .MW_out    (MW_out),
        .MReg_out  (MReg_out),
`ifdef EX_MEM_PIPE_PERF_EN
        .EnRW_out  (EnRW_out),
        .stall_cnt (stall_cnt),
        .bubble_cnt(bubble_cnt),
        .flush_cnt (flush_cnt)
`else
        .EnRW_out  (EnRW_out)
`endif
    );

    always #5 clk = ~clk;

    // Reference state: beats currently held by the stage, oldest first
    logic [PW-1:0] exp_q[$];
    int            vectors = 0;
    int            fails   = 0;

    // Expectations captured by the driver for the monitor
    logic exp_ov = 1'b0;
    logic exp_ir = 1'b1;
    logic exp_zero_data = 1'b0;
    logic post_reset = 1'b1;
    longint m_stall = 0, m_bubble = 0, m_flush = 0;
    longint s_stall = 0, s_bubble = 0, s_flush = 0;
    localparam longint c_SAT = (64'd1 << CNT_W) - 1;

    function automatic logic [PW-1:0] mk(input logic [31:0] alu, input logic [31:0] rd2,
                                          input logic [3:0] wn, input logic [3:0] ctl);
        return {alu, rd2, wn, ctl};
    endfunction

    task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] req);
        vectors++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    // One clock cycle of stimulus; model advances for the upcoming edge
    task automatic step(input bit iv, input bit ordy, input bit fl, input bit rst,
                        input logic [PW-1:0] pl);
        int  n;
        bit  rel, acc;
        logic [PW-1:0] front;
        @(negedge clk);
        n             = exp_q.size();
        exp_ov        = (n > 0);
        exp_ir        = (n < 2);
        exp_zero_data = post_reset;
        s_stall = m_stall; s_bubble = m_bubble; s_flush = m_flush;

        reset     = rst;
        flush     = fl;
        in_valid  = iv;
        out_ready = ordy;
        {ALU_in, RD2_in, WN_in, MR_in, MW_in, MReg_in, EnRW_in} = pl;

        if (rst) begin
            exp_q.delete();
            post_reset = 1'b1;
            m_stall = 0; m_bubble = 0; m_flush = 0;
        end else begin
            post_reset = 1'b0;
            rel = (n > 0) && ordy;
            acc = iv && (n < 2);
            if (n > 0 && !ordy && m_stall < c_SAT) m_stall++;
            if (n == 0 && m_bubble < c_SAT) m_bubble++;
            if (fl && ((n - int'(rel)) > 0 || acc) && m_flush < c_SAT) m_flush++;
            if (fl) begin
                if (rel) begin
                    front = exp_q[0];
                    exp_q.delete();
                    exp_q.push_back(front);
                end else begin
                    exp_q.delete();
                end
            end else if (acc) begin
                exp_q.push_back(pl);
            end
        end
    endtask

    function automatic logic [PW-1:0] rnd_pl();
        logic [31:0] a, b, c;
        a = $urandom; b = $urandom; c = $urandom;
        return mk(a, b, c[3:0], c[7:4]);
    endfunction

    // Monitor: handshake/gating checks plus scoreboard pop on each release
    initial begin
        logic [PW-1:0] act;
        logic [PW-1:0] req;
        forever begin
            @(negedge clk);
            #4;
            check("out_valid", {{(PW-1){1'b0}}, out_valid}, {{(PW-1){1'b0}}, exp_ov});
            check("in_ready", {{(PW-1){1'b0}}, in_ready}, {{(PW-1){1'b0}}, exp_ir});
            if (!exp_ov)
                check("ctrl_gated", {{(PW-4){1'b0}}, MR_out, MW_out, MReg_out, EnRW_out}, '0);
            if (exp_zero_data)
                check("reset_data", {ALU_out, RD2_out, WN_out, 4'b0}, '0);
`ifdef EX_MEM_PIPE_PERF_EN
            check("stall_cnt", PW'(stall_cnt), PW'(s_stall));
            check("bubble_cnt", PW'(bubble_cnt), PW'(s_bubble));
            check("flush_cnt", PW'(flush_cnt), PW'(s_flush));
`endif
            if (out_valid === 1'b1 && out_ready && !reset) begin
                act = {ALU_out, RD2_out, WN_out, MR_out, MW_out, MReg_out, EnRW_out};
                if (exp_q.size() == 0) begin
                    vectors++;
                    fails++;
                    $display("FAIL unexpected_beat: got %h, expected no beat at %0t", act, $time);
                end else begin
                    req = exp_q.pop_front();
                    check("beat", act, req);
                end
            end
        end
    end

    // Stimulus
    initial begin
        logic [PW-1:0] z;
        z = '0;
        // Reset
        step(0, 0, 0, 1, z);
        step(0, 0, 0, 1, z);
        step(0, 1, 0, 0, z);

        // Streaming with MW=1, full throughput
        for (int i = 1; i <= 8; i++)
            step(1, 1, 0, 0, mk(i, 32'hA000 + i, i[3:0], 4'b0100));
        repeat (2) step(0, 1, 0, 0, z);

        // Backpressure: A, B, C back-to-back; out_ready low 3 cycles
        step(1, 1, 0, 0, mk(32'hA, 1, 1, 4'b0001));
        step(1, 0, 0, 0, mk(32'hB, 2, 2, 4'b0010));
        step(1, 0, 0, 0, mk(32'hC, 3, 3, 4'b1000));
        step(1, 0, 0, 0, mk(32'hC, 3, 3, 4'b1000));
        step(1, 1, 0, 0, mk(32'hC, 3, 3, 4'b1000));
        step(1, 1, 0, 0, mk(32'hC, 3, 3, 4'b1000));
        repeat (3) step(0, 1, 0, 0, z);

        // Flush with M and S full and a beat incoming
        step(1, 0, 0, 0, mk(32'h11, 0, 1, 4'b0101));
        step(1, 0, 0, 0, mk(32'h22, 0, 2, 4'b0101));
        step(1, 0, 1, 0, mk(32'h33, 0, 3, 4'b0101));
        step(1, 1, 0, 0, mk(32'h44, 0, 4, 4'b0101));
        repeat (2) step(0, 1, 0, 0, z);

        // Flush in the same edge that releases 0x55
        step(1, 0, 0, 0, mk(32'h55, 0, 5, 4'b0111));
        step(0, 1, 1, 0, z);
        repeat (2) step(0, 1, 0, 0, z);

        // Reset mid-stream with S full
        step(1, 0, 0, 0, mk(32'h66, 0, 6, 4'b1111));
        step(1, 0, 0, 0, mk(32'h77, 0, 7, 4'b1111));
        step(1, 0, 0, 1, mk(32'h88, 0, 8, 4'b1111));
        step(0, 0, 0, 1, z);
        step(0, 1, 0, 0, z);

        // Randomised traffic with occasional flush and reset
        for (int i = 0; i < 3000; i++)
            step(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 32) == 0,
                 ($urandom % 250) == 0, rnd_pl());

        // Drain
        repeat (4) step(0, 1, 0, 0, z);
        @(negedge clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ex_mem_pipe_stage.md
Name: ex_mem_pipe_stage

Overview:
- Parametrised EX->MEM pipeline stage register: next generation of the fixed 32-bit EX/MEM latch.
- Adds a valid/ready handshake, a 2-entry skid buffer, and flush/bubble insertion.
- Sits between the ALU stage and the data-memory stage. Absorbs a multi-cycle memory stall without a combinational ready path back into EX.
- Payload: ALU result, store data, write-register number, and the MR/MW/MReg/EnRW control bits.

Parameters:
- DATA_W, 32, width of ALU result and store data
- REG_AW, 4, width of write-register number
- CNT_W, 16, width of performance counters (used only with optional feature)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  kill all held and incoming beats this cycle (branch/exception)
- in_valid  in  1  EX presents a beat
- in_ready  out  1  stage can accept a beat; registered
- ALU_in  in  DATA_W  ALU result
- RD2_in  in  DATA_W  store data
- WN_in  in  REG_AW  write-register number
- MR_in, MW_in, MReg_in, EnRW_in  in  1 each  mem-read, mem-write, mem-to-reg select, register-write enable
- out_valid  out  1  beat presented to MEM
- out_ready  in  1  MEM accepts beat
- ALU_out, RD2_out  out  DATA_W  held payload
- WN_out  out  REG_AW  held payload
- MR_out, MW_out, MReg_out, EnRW_out  out  1 each  held control; forced 0 when out_valid=0

Behaviour:
- Storage: main entry M (drives outputs) and skid entry S, each with a valid bit. All state is registered.
- Reset (sync, reset=1 at posedge): M and S invalid; all payload regs 0; out_valid=0; in_ready=1; all *_out = 0. Reset overrides flush and the handshake.
- in_ready = !S.valid, registered, so there is no comb path from out_ready.
- Accept: in_valid & in_ready at a posedge.
- Release: out_valid & out_ready at a posedge.
- Latency 1 cycle: a beat accepted at edge N appears on the outputs after edge N when M was empty or released at N. Throughput is 1 beat/cycle with out_ready held high.
- Transitions per edge (flush=0):
  - Accept into M if M is empty or released this edge and S is empty.
  - Otherwise accept into S, which happens only when M is held and S is empty.
  - On release with S valid: S moves to M and S empties, so in_ready rises next cycle.
  - Accept and release in the same edge with S empty: new beat replaces M.
- Ordering is strictly FIFO; no beat is duplicated or dropped absent flush.
- flush=1 at an edge: M and S become invalid. Any beat accepted that edge is discarded. Payload regs hold their stale data, but control outputs read 0 because out_valid=0. in_ready=1 next cycle.
- A beat released in the same edge as flush is considered delivered; MEM sampled it.
- Control gating: MR_out/MW_out/MReg_out/EnRW_out = stored bit & out_valid. A bubble therefore never writes memory or the register file.
- Data outputs ALU_out/RD2_out/WN_out are unspecified-but-stable while out_valid=0. They are 0 after reset.
- out_valid and payload are stable while out_valid & !out_ready.

Optional Feature:
- Macro EX_MEM_PIPE_PERF_EN.
- When defined, adds outputs:
  - stall_cnt (CNT_W): counts cycles with out_valid & !out_ready.
  - bubble_cnt (CNT_W): counts cycles with !out_valid.
  - flush_cnt (CNT_W): counts flush edges that invalidated at least one beat.
- Counters saturate at all-ones and clear on reset.
- When undefined, these ports and registers do not exist and behaviour is otherwise identical.

Decomposition:
- Shared package pipe_pkg holds:
  - exmem_ctrl_t struct {MR, MW, MReg, EnRW}.
  - Parametrised payload packing width constant.
  - Skid-state encoding, if an enum is used.
- One natural sub-module, pipe_skid_buf: a generic 2-entry skid buffer over a packed payload of width W with flush. ex_mem_pipe_stage instantiates it and adds control gating and the counters.

Test Plan:
- Reset: assert reset 2 cycles mid-stream with S full -> next cycle out_valid=0, in_ready=1, all *_out=0.
- Streaming: out_ready=1; send ALU_in=1..8, WN_in=1..8, MW=1 one per cycle -> outputs 1..8 in order, 1-cycle latency, in_ready always 1.
- Backpressure: send A,B,C back-to-back; drop out_ready for 3 cycles after A appears -> A held stable, B lands in S, in_ready=0 one cycle after B accepted, C waits; restore out_ready -> A,B,C delivered, none lost.
- Flush: M=0x11 with MW=1, S=0x22, incoming 0x33; pulse flush -> next cycle out_valid=0, MW_out=0, EnRW_out=0; next beat 0x44 emerges alone.
- Flush with release: out_ready=1 and flush in the same edge as beat 0x55 -> 0x55 counted delivered; no 0x55 re-emitted.
- Perf (EX_MEM_PIPE_PERF_EN): 5 stall cycles, 3 idle cycles, 1 effective flush -> stall_cnt=5, bubble_cnt≥3, flush_cnt=1. With CNT_W=2, 6 stalls -> stall_cnt=3.
